// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_8bit_subtractor.sv
// Bit-serial subtractor, LSB first, with valid/ready on both sides.
// Optional signed overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_8bit_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  sub_state_t       state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sd_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             d_s;
  logic             bo_s;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf_q;
`endif

  full_subtractor u_fs (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (br_q),
    .d    (d_s),
    .bout (bo_s)
  );

  // Control FSM and serial datapath share one register block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= ZERO_W;
      sb_q    <= ZERO_W;
      sd_q    <= ZERO_W;
      cnt_q   <= CNT_ZERO;
      br_q    <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= SHIFT;
            sa_q    <= a;
            sb_q    <= b;
            br_q    <= bin;
            cnt_q   <= CNT_ZERO;
            sd_q    <= ZERO_W;
          end
        end
        SHIFT: begin
          sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
          sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
          sd_q  <= {d_s, sd_q[WIDTH-1:1]};
          br_q  <= bo_s;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // Borrow into the MSB step vs. borrow out of it
            ovf_q   <= br_q ^ bo_s;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = sd_q;
  assign bout      = br_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_8bit_subtractor.sv
// Self-checking bench for serial_8bit_subtractor (8-bit), randomized against an arithmetic model.
module tb_serial_8bit_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_8bit_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .bout      (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned difference with borrow, and signed overflow
  function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return {(r < 0), r[7:0]};
  endfunction

  function automatic logic ref_ovf(input logic [7:0] x, input logic [7:0] y, input logic c);
    int sx, sy, s;
    sx = (x >= 8'd128) ? int'(x) - 256 : int'(x);
    sy = (y >= 8'd128) ? int'(y) - 256 : int'(y);
    s  = sx - sy - int'(c);
    return (s < -128) || (s > 127);
  endfunction

  // Drives one operation end to end and reports what was observed
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                       input int pre_gap, input int hold, input bit noise,
                       output logic [7:0] rd, output logic rb, output logic ro,
                       output int lat, output int busy_bad, output int hold_bad,
                       output bit retire_ok);
    int w;
    repeat (pre_gap) @(negedge clk);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = noise;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    lat = 0;
    busy_bad = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_bad++;
      @(negedge clk);
      lat++;
    end
    if (in_ready) busy_bad++;
    rd = diff;
    rb = bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    ro = ovf;
`else
    ro = 1'b0;
`endif
    hold_bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (diff !== rd || bout !== rb || out_valid !== 1'b1 || in_ready !== 1'b0) hold_bad++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    retire_ok = (in_ready === 1'b1) && (out_valid === 1'b0);
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b diff=%h bout=%b, want 1 0 00 0",
               in_ready, out_valid, diff, bout);
    end
  endtask

  task automatic test_directed();
    logic [7:0] va [4] = '{8'h05, 8'h00, 8'h80, 8'h10};
    logic [7:0] vb [4] = '{8'h03, 8'h01, 8'h01, 8'h0F};
    logic       vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] ed [4] = '{8'h02, 8'hFF, 8'h7F, 8'h00};
    logic       eb [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] rd;
    logic rb, ro;
    int lat, bb, hb;
    bit rok;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], vc[i], 1, 0, 1'b0, rd, rb, ro, lat, bb, hb, rok);
      checks++;
      if (rd !== ed[i] || rb !== eb[i]) begin
        errors++;
        $display("FAIL directed_%0d: diff=%h bout=%b, want diff=%h bout=%b", i, rd, rb, ed[i], eb[i]);
      end
      checks++;
      if (lat != 8) begin
        errors++;
        $display("FAIL latency_%0d: out_valid after %0d edges, want 8", i, lat);
      end
      checks++;
      if (bb != 0 || !rok) begin
        errors++;
        $display("FAIL handshake_%0d: in_ready high while busy %0d times, retire_ok=%b, want 0 and 1", i, bb, rok);
      end
`ifdef SERIAL_SUB_OVERFLOW_EN
      checks++;
      if (ro !== eo[i]) begin
        errors++;
        $display("FAIL ovf_%0d: ovf=%b, want %b", i, ro, eo[i]);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] rd;
    logic rb, ro;
    int lat, bb, hb;
    bit rok;
    do_op(8'hA5, 8'h5A, 1'b0, 1, 5, 1'b1, rd, rb, ro, lat, bb, hb, rok);
    checks++;
    if (rd !== 8'h4B || rb !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_value: diff=%h bout=%b, want 4b 0", rd, rb);
    end
    checks++;
    if (hb != 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d unstable cycles, want 0", hb);
    end
    checks++;
    if (!rok || bb != 0) begin
      errors++;
      $display("FAIL backpressure_retire: retire_ok=%b busy_ready=%0d, want 1 0", rok, bb);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] rd;
    logic rb, ro;
    int lat, bb, hb;
    bit rok;
    @(negedge clk);
    a = 8'hFF; b = 8'h00; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op: in_ready=%b out_valid=%b diff=%h bout=%b, want 1 0 00 0",
               in_ready, out_valid, diff, bout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'hFF, 8'hFF, 1'b1, 1, 0, 1'b0, rd, rb, ro, lat, bb, hb, rok);
    checks++;
    if (rd !== 8'hFF || rb !== 1'b1 || lat != 8) begin
      errors++;
      $display("FAIL after_reset_op: diff=%h bout=%b lat=%0d, want ff 1 8", rd, rb, lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] ta, tbv, rd;
    logic tc, rb, ro;
    logic [8:0] exp;
    int lat, bb, hb, done_cnt;
    bit rok;
    done_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      ta  = 8'($urandom);
      tbv = 8'($urandom);
      tc  = 1'($urandom);
      exp = ref_sub(ta, tbv, tc);
      do_op(ta, tbv, tc, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
            1'($urandom), rd, rb, ro, lat, bb, hb, rok);
      if (lat == 8) done_cnt++;
      checks++;
      if (rd !== exp[7:0] || rb !== exp[8]) begin
        errors++;
        $display("FAIL random_%0d: %h-%h-%b gave diff=%h bout=%b, want diff=%h bout=%b",
                 i, ta, tbv, tc, rd, rb, exp[7:0], exp[8]);
      end
      checks++;
      if (lat != 8 || bb != 0 || hb != 0 || !rok) begin
        errors++;
        $display("FAIL random_proto_%0d: lat=%0d busy_ready=%0d hold_bad=%0d retire_ok=%b, want 8 0 0 1",
                 i, lat, bb, hb, rok);
      end
`ifdef SERIAL_SUB_OVERFLOW_EN
      checks++;
      if (ro !== ref_ovf(ta, tbv, tc)) begin
        errors++;
        $display("FAIL random_ovf_%0d: ovf=%b, want %b", i, ro, ref_ovf(ta, tbv, tc));
      end
`endif
    end
    checks++;
    if (done_cnt != 1000) begin
      errors++;
      $display("FAIL random_count: %0d results completed, want 1000", done_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; bin = 1'b0;
    #3;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
